// File: rtl/branch_predictor.sv
// rtl/branch_predictor.sv - fetch-stage 2-bit branch predictor with BTB
//
// Direct-mapped table of 2^IDX_BITS entries, indexed by pc[IDX_BITS:1].
// Each entry holds valid, tag, target and a 2-bit saturating counter.
//
// Ports:
//   clk, rst           clock, synchronous active-high reset
//   fetch_pc           PC in fetch; looked up combinationally
//   pred_taken         hit and counter MSB set
//   pred_target        stored target on hit, else 0
//   upd_valid          branch resolved in EX this cycle
//   upd_pc             PC of the resolved branch
//   upd_taken          actual direction
//   upd_target         actual target
//   upd_pred_taken     prediction that travelled with the branch
//   upd_pred_target    predicted target that travelled with the branch
//   mispredict         registered mispredict flag for the previous update
//   branch_cnt         saturating count of resolved branches
//   mispred_cnt        saturating count of mispredicts
module branch_predictor #(
    parameter int IDX_BITS = 4,
    parameter int PC_W     = 16,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [PC_W-1:0]  fetch_pc,
    output logic             pred_taken,
    output logic [PC_W-1:0]  pred_target,
    input  logic             upd_valid,
    input  logic [PC_W-1:0]  upd_pc,
    input  logic             upd_taken,
    input  logic [PC_W-1:0]  upd_target,
    input  logic             upd_pred_taken,
    input  logic [PC_W-1:0]  upd_pred_target,
    output logic             mispredict,
    output logic [CNT_W-1:0] branch_cnt,
    output logic [CNT_W-1:0] mispred_cnt
);

    localparam int ENTRIES = 1 << IDX_BITS;
    localparam int TAG_W   = PC_W - IDX_BITS - 1;

    logic             r_valid  [ENTRIES];
    logic [TAG_W-1:0] r_tag    [ENTRIES];
    logic [PC_W-1:0]  r_target [ENTRIES];
    logic [1:0]       r_ctr    [ENTRIES];

    logic             r_mispredict;
    logic [CNT_W-1:0] r_branch_cnt;
    logic [CNT_W-1:0] r_mispred_cnt;

    logic [IDX_BITS-1:0] w_fidx;
    logic [TAG_W-1:0]    w_ftag;
    logic                w_fhit;
    logic [IDX_BITS-1:0] w_uidx;
    logic [TAG_W-1:0]    w_utag;
    logic                w_uhit;
    logic                w_mispred;

    // Lookup reads the registered table only, so a same-cycle update to the
    // same index is not visible until the following cycle.
    assign w_fidx = fetch_pc[IDX_BITS:1];
    assign w_ftag = fetch_pc[PC_W-1:IDX_BITS+1];
    assign w_fhit = r_valid[w_fidx] && (r_tag[w_fidx] == w_ftag);

    assign pred_taken  = w_fhit & r_ctr[w_fidx][1];
    assign pred_target = w_fhit ? r_target[w_fidx] : '0;

    assign w_uidx = upd_pc[IDX_BITS:1];
    assign w_utag = upd_pc[PC_W-1:IDX_BITS+1];
    assign w_uhit = r_valid[w_uidx] && (r_tag[w_uidx] == w_utag);

    // Judged purely against the prediction carried down the pipe; the table
    // may have changed since that prediction was made.
    assign w_mispred = (upd_taken != upd_pred_taken) ||
                       (upd_taken && upd_pred_taken && (upd_target != upd_pred_target));

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                r_valid[i]  <= 1'b0;
                r_tag[i]    <= '0;
                r_target[i] <= '0;
                r_ctr[i]    <= 2'b01;
            end
            r_mispredict  <= 1'b0;
            r_branch_cnt  <= '0;
            r_mispred_cnt <= '0;
        end else begin
            r_mispredict <= upd_valid && w_mispred;
            if (upd_valid) begin
                if (r_branch_cnt != {CNT_W{1'b1}})
                    r_branch_cnt <= r_branch_cnt + 1'b1;
                if (w_mispred && (r_mispred_cnt != {CNT_W{1'b1}}))
                    r_mispred_cnt <= r_mispred_cnt + 1'b1;

                if (w_uhit) begin
                    if (upd_taken) begin
                        if (r_ctr[w_uidx] != 2'b11)
                            r_ctr[w_uidx] <= r_ctr[w_uidx] + 2'b01;
                        r_target[w_uidx] <= upd_target;
                    end else if (r_ctr[w_uidx] != 2'b00) begin
                        r_ctr[w_uidx] <= r_ctr[w_uidx] - 2'b01;
                    end
                end else if (upd_taken) begin
                    // Taken miss evicts whatever lives at this index; a
                    // not-taken miss leaves the table alone.
                    r_valid[w_uidx]  <= 1'b1;
                    r_tag[w_uidx]    <= w_utag;
                    r_target[w_uidx] <= upd_target;
                    r_ctr[w_uidx]    <= 2'b10;
                end
            end
        end
    end

    assign mispredict  = r_mispredict;
    assign branch_cnt  = r_branch_cnt;
    assign mispred_cnt = r_mispred_cnt;

endmodule

// File: tb/tb_branch_predictor.sv
// tb/tb_branch_predictor.sv - directed self-checking bench for branch_predictor
module tb_branch_predictor;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] fetch_pc;
    logic        pred_taken;
    logic [15:0] pred_target;
    logic        upd_valid;
    logic [15:0] upd_pc;
    logic        upd_taken;
    logic [15:0] upd_target;
    logic        upd_pred_taken;
    logic [15:0] upd_pred_target;
    logic        mispredict;
    logic [15:0] branch_cnt;
    logic [15:0] mispred_cnt;

    int n_checks = 0;
    int n_pass   = 0;

    branch_predictor #(.IDX_BITS(4), .PC_W(16), .CNT_W(16)) dut (
        .clk             (clk),
        .rst             (rst),
        .fetch_pc        (fetch_pc),
        .pred_taken      (pred_taken),
        .pred_target     (pred_target),
        .upd_valid       (upd_valid),
        .upd_pc          (upd_pc),
        .upd_taken       (upd_taken),
        .upd_target      (upd_target),
        .upd_pred_taken  (upd_pred_taken),
        .upd_pred_target (upd_pred_target),
        .mispredict      (mispredict),
        .branch_cnt      (branch_cnt),
        .mispred_cnt     (mispred_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic upd(input logic [15:0] pc, input logic tk, input logic [15:0] tgt,
                       input logic ptk, input logic [15:0] ptgt);
        upd_valid       = 1'b1;
        upd_pc          = pc;
        upd_taken       = tk;
        upd_target      = tgt;
        upd_pred_taken  = ptk;
        upd_pred_target = ptgt;
        tick();
        upd_valid = 1'b0;
    endtask

    task automatic look(input string tag, input logic [15:0] pc, input logic exp_tk,
                        input logic [15:0] exp_tgt);
        fetch_pc = pc;
        #1;
        check({tag, "_taken"}, {31'd0, pred_taken}, {31'd0, exp_tk});
        check({tag, "_target"}, {16'd0, pred_target}, {16'd0, exp_tgt});
    endtask

    initial begin
        rst = 1'b1;
        fetch_pc = 16'h0010;
        upd_valid = 1'b0;
        upd_pc = '0;
        upd_taken = 1'b0;
        upd_target = '0;
        upd_pred_taken = 1'b0;
        upd_pred_target = '0;
        tick();
        rst = 1'b0;

        // Reset state
        look("rst_lookup", 16'h0010, 1'b0, 16'h0000);
        check("rst_mispredict", {31'd0, mispredict}, 32'd0);
        check("rst_branch_cnt", {16'd0, branch_cnt}, 32'd0);
        check("rst_mispred_cnt", {16'd0, mispred_cnt}, 32'd0);

        // First taken update allocates with ctr=10
        upd(16'h0010, 1'b1, 16'h0040, 1'b0, 16'h0000);
        check("alloc_mispredict", {31'd0, mispredict}, 32'd1);
        check("alloc_mispred_cnt", {16'd0, mispred_cnt}, 32'd1);
        check("alloc_branch_cnt", {16'd0, branch_cnt}, 32'd1);
        look("alloc_lookup", 16'h0010, 1'b1, 16'h0040);

        // Two correctly predicted taken updates: 10 -> 11 -> 11
        upd(16'h0010, 1'b1, 16'h0040, 1'b1, 16'h0040);
        check("tk1_mispredict", {31'd0, mispredict}, 32'd0);
        upd(16'h0010, 1'b1, 16'h0040, 1'b1, 16'h0040);
        check("tk2_mispredict", {31'd0, mispredict}, 32'd0);

        // Not-taken walk down: 11 -> 10 -> 01 -> 00, then stays 00
        upd(16'h0010, 1'b0, 16'h0000, 1'b0, 16'h0000);
        look("nt1", 16'h0010, 1'b1, 16'h0040);
        upd(16'h0010, 1'b0, 16'h0000, 1'b0, 16'h0000);
        look("nt2", 16'h0010, 1'b0, 16'h0040);
        upd(16'h0010, 1'b0, 16'h0000, 1'b0, 16'h0000);
        look("nt3", 16'h0010, 1'b0, 16'h0040);
        upd(16'h0010, 1'b0, 16'h0000, 1'b0, 16'h0000);
        check("nt4_mispredict", {31'd0, mispredict}, 32'd0);
        // From 00 one taken gives 01 (still not taken); from 01 it would give 10
        upd(16'h0010, 1'b1, 16'h0040, 1'b0, 16'h0000);
        look("sat_low", 16'h0010, 1'b0, 16'h0040);
        check("mid_branch_cnt", {16'd0, branch_cnt}, 32'd8);
        check("mid_mispred_cnt", {16'd0, mispred_cnt}, 32'd2);

        // Aliasing at index 8
        upd(16'h0030, 1'b1, 16'h0100, 1'b0, 16'h0000);
        look("alias_old", 16'h0010, 1'b0, 16'h0000);
        look("alias_new", 16'h0030, 1'b1, 16'h0100);
        upd(16'h0050, 1'b0, 16'h0000, 1'b0, 16'h0000);
        look("nt_miss_keep", 16'h0030, 1'b1, 16'h0100);
        look("nt_miss_noalloc", 16'h0050, 1'b0, 16'h0000);

        // Same-cycle lookup and allocation: no bypass
        fetch_pc        = 16'h0020;
        upd_valid       = 1'b1;
        upd_pc          = 16'h0020;
        upd_taken       = 1'b1;
        upd_target      = 16'h0060;
        upd_pred_taken  = 1'b0;
        upd_pred_target = 16'h0000;
        #1;
        check("bypass_same_cycle", {31'd0, pred_taken}, 32'd0);
        tick();
        upd_valid = 1'b0;
        look("bypass_next", 16'h0020, 1'b1, 16'h0060);

        // Direction right, target wrong
        upd(16'h0020, 1'b1, 16'h0048, 1'b1, 16'h0044);
        check("tgt_mispredict", {31'd0, mispredict}, 32'd1);
        look("tgt_updated", 16'h0020, 1'b1, 16'h0048);
        upd(16'h0020, 1'b1, 16'h0048, 1'b1, 16'h0048);
        check("tgt_match", {31'd0, mispredict}, 32'd0);
        tick();
        check("mispredict_one_cycle", {31'd0, mispredict}, 32'd0);

        // Reset wins over a concurrent update
        rst = 1'b1;
        upd(16'h0040, 1'b1, 16'h0080, 1'b0, 16'h0000);
        rst = 1'b0;
        look("rst2_0020", 16'h0020, 1'b0, 16'h0000);
        look("rst2_0030", 16'h0030, 1'b0, 16'h0000);
        look("rst2_0040", 16'h0040, 1'b0, 16'h0000);
        check("rst2_mispredict", {31'd0, mispredict}, 32'd0);
        check("rst2_branch_cnt", {16'd0, branch_cnt}, 32'd0);
        check("rst2_mispred_cnt", {16'd0, mispred_cnt}, 32'd0);

        // Counter saturation: 0xFFFF + 2 correctly predicted updates
        upd_valid       = 1'b1;
        upd_pc          = 16'h0002;
        upd_taken       = 1'b0;
        upd_target      = 16'h0000;
        upd_pred_taken  = 1'b0;
        upd_pred_target = 16'h0000;
        for (int i = 0; i < 16'hFFFF + 2; i++) tick();
        upd_valid = 1'b0;
        check("sat_branch_cnt", {16'd0, branch_cnt}, 32'h0000FFFF);
        check("sat_mispred_cnt", {16'd0, mispred_cnt}, 32'd0);
        tick();
        check("sat_branch_hold", {16'd0, branch_cnt}, 32'h0000FFFF);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
